// File: rtl/switch_pkg.sv
// Shared SwitchFlip definitions: FSM state encoding and default build constants.
package switch_pkg;

   localparam int unsigned DefSyncStages     = 2;
   localparam int unsigned DefDebounceCycles = 4;
   localparam int unsigned DefCntW           = 8;

   typedef enum logic [1:0] {
      STABLE_LOW,
      CONFIRM_HIGH,
      STABLE_HIGH,
      CONFIRM_LOW
   } switch_state_e;

endpackage

// File: rtl/switch_flip_gen_if.sv
// SwitchFlip link: raw switch pin in, debounced level/strobe/count out.
interface switch_flip_gen_if #(
   parameter int unsigned CNT_W = switch_pkg::DefCntW
) ();

   logic             RawSwitch;
   logic             SwitchFlip;
   logic             FlipEvent;
   logic [CNT_W-1:0] FlipCount;

   // Generator side: samples the pin, drives the debounced outputs.
   modport master (
      input  RawSwitch,
      output SwitchFlip,
      output FlipEvent,
      output FlipCount
   );

   // Consumer side (port controller, board pin driver).
   modport slave (
      output RawSwitch,
      input  SwitchFlip,
      input  FlipEvent,
      input  FlipCount
   );

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input, synchronous reset.
module sync_chain
   import switch_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DefSyncStages
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] stage_q;
   logic [SYNC_STAGES-1:0] stage_d;

   // Shift the pin into stage 0; the oldest sample leaves at the top.
   always_comb begin
      stage_d = {stage_q[SYNC_STAGES-2:0], d_i};
   end

   // Register the chain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_flip_gen.sv
// Debounces a bouncing board switch into a committed level, a one-cycle change
// strobe and a wrapping change counter.
module switch_flip_gen
   import switch_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DefSyncStages,
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned CNT_W           = DefCntW
) (
   input  logic              Clock,
   input  logic              Reset,
   switch_flip_gen_if.master bus
);

   localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   logic             syncd;
   switch_state_e    state_q, state_d;
   logic [DbW-1:0]   count_q, count_d;
   logic             flip_q, flip_d;
   logic             event_q, event_d;
   logic [CNT_W-1:0] flips_q, flips_d;
   logic             commit;

   sync_chain #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (Clock),
      .rst_i (Reset),
      .d_i   (bus.RawSwitch),
      .q_o   (syncd)
   );

   // Next-state: count consecutive disagreeing samples, commit on the last one.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      flip_d  = flip_q;
      event_d = 1'b0;
      flips_d = flips_q;
      commit  = 1'b0;
      unique case (state_q)
         STABLE_LOW: begin
            if (syncd) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  commit = 1'b1;
               end else begin
                  state_d = CONFIRM_HIGH;
                  count_d = DbW'(1);
               end
            end
         end
         CONFIRM_HIGH: begin
            if (!syncd) begin
               state_d = STABLE_LOW;
               count_d = '0;
            end else if (count_q == DbLast) begin
               commit = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         STABLE_HIGH: begin
            if (!syncd) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  commit = 1'b1;
               end else begin
                  state_d = CONFIRM_LOW;
                  count_d = DbW'(1);
               end
            end
         end
         CONFIRM_LOW: begin
            if (syncd) begin
               state_d = STABLE_HIGH;
               count_d = '0;
            end else if (count_q == DbLast) begin
               commit = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: begin
            state_d = STABLE_LOW;
            count_d = '0;
         end
      endcase
      // A commit always lands in the stable state opposite the current level.
      if (commit) begin
         state_d = flip_q ? STABLE_LOW : STABLE_HIGH;
         count_d = '0;
         flip_d  = ~flip_q;
         event_d = 1'b1;
         flips_d = flips_q + 1'b1;
      end
   end

   // State and registered outputs; reset wins over any transition.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= STABLE_LOW;
         count_q <= '0;
         flip_q  <= 1'b0;
         event_q <= 1'b0;
         flips_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         flip_q  <= flip_d;
         event_q <= event_d;
         flips_q <= flips_d;
      end
   end

   assign bus.SwitchFlip = flip_q;
   assign bus.FlipEvent  = event_q;
   assign bus.FlipCount  = flips_q;

endmodule
